// File: rtl/chip8_timer_pkg.sv
// Shared constants, channel index type and prescaler divisor helper for the CHIP-8 timer bank.
package chip8_timer_pkg;

  localparam int CH_DELAY = 0;
  localparam int CH_SOUND = 1;
  localparam int MAX_CH   = 8;

  typedef logic [$clog2(MAX_CH)-1:0] chan_idx_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/chip8_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks; pause freezes it in phase.
module chip8_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("chip8_tick_gen: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // A pending tick is held through a pause so it fires right after release.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_q;
    if (!pause) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q & ~pause;

endmodule

// File: rtl/chip8_timer_bank.sv
// Bank of NUM_CH CPU-loadable down-counting timers with an internal tick prescaler.
// Optional CHIP8_TIMER_PAUSE_EN adds a pause input that freezes the prescaler and all decrements.
module chip8_timer_bank
  import chip8_timer_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 8,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 60,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CHIP8_TIMER_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] expired,
  output logic              tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("chip8_timer_bank: NUM_CH must be 1..8");
  end

  logic pause_w;
`ifdef CHIP8_TIMER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  chip8_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .pause (pause_w),
    .tick  (tick)
  );

  logic [WIDTH-1:0] cnt_q [NUM_CH];
  logic             exp_q [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_d;
    logic             exp_d;
    logic             wr_hit;

    assign wr_hit = wr_en && (wr_ch == CH_W'(i));

    // A write in a tick cycle wins: the loaded value is not decremented and never expires.
    always_comb begin
      cnt_d = cnt_q[i];
      exp_d = 1'b0;
      if (wr_hit) begin
        cnt_d = wr_data;
      end else if (tick && (cnt_q[i] != '0)) begin
        cnt_d = cnt_q[i] - WIDTH'(1);
        exp_d = (cnt_q[i] == WIDTH'(1));
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q[i] <= '0;
        exp_q[i] <= 1'b0;
      end else begin
        cnt_q[i] <= cnt_d;
        exp_q[i] <= exp_d;
      end
    end

    assign active[i]  = |cnt_q[i];
    assign expired[i] = exp_q[i];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_data = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_chip8_timer_bank.sv
// Self-checking bench for chip8_timer_bank with DIV = 8 and two channels.
module tb_chip8_timer_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause_r;
  logic       wr_en;
  logic       wr_ch;
  logic [7:0] wr_data;
  logic       rd_ch;
  logic [7:0] rd_data;
  logic [1:0] active;
  logic [1:0] expired;
  logic       tick;

  always #5 clk = ~clk;

  chip8_timer_bank #(
    .NUM_CH  (2),
    .WIDTH   (8),
    .CLK_HZ  (8),
    .TICK_HZ (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef CHIP8_TIMER_PAUSE_EN
    .pause   (pause_r),
`endif
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .rd_ch   (rd_ch),
    .rd_data (rd_data),
    .active  (active),
    .expired (expired),
    .tick    (tick)
  );

  // Reference model: counts, expiry flags, tick and edges since the last reset.
  logic [7:0]  m_cnt [2];
  logic [1:0]  m_exp;
  logic        m_tick;
  int          m_n;
  logic [12:0] exp_q[$];

  logic       o_tick;
  logic [7:0] o_rd;
  logic [1:0] o_act;
  logic [1:0] o_exp;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance model, push expectation, compare at negedge.
  task automatic drive(input logic rst, input logic we, input logic wch,
                       input logic [7:0] wd, input logic rch, input logic pz);
    logic        dec;
    logic [12:0] e;
    reset = rst; wr_en = we; wr_ch = wch; wr_data = wd; rd_ch = rch; pause_r = pz;
    dec = m_tick && !pz;
    for (int c = 0; c < 2; c++) begin
      m_exp[c] = 1'b0;
      if (rst) begin
        m_cnt[c] = 8'd0;
      end else if (we && (wch == c[0])) begin
        m_cnt[c] = wd;
      end else if (dec && m_cnt[c] != 8'd0) begin
        m_cnt[c] = m_cnt[c] - 8'd1;
        m_exp[c] = (m_cnt[c] == 8'd0);
      end
    end
    if (rst) begin
      m_n = 0;
      m_tick = 1'b0;
    end else if (!pz) begin
      m_n = m_n + 1;
      m_tick = (m_n % 8 == 0);
    end
    exp_q.push_back({m_tick & ~pz, m_cnt[1] != 8'd0, m_cnt[0] != 8'd0, m_exp, m_cnt[rch]});
    @(negedge clk);
    e = exp_q.pop_front();
    o_tick = tick; o_rd = rd_data; o_act = active; o_exp = expired;
    check("tick",    {31'd0, o_tick}, {31'd0, e[12]});
    check("active",  {30'd0, o_act},  {30'd0, e[11:10]});
    check("expired", {30'd0, o_exp},  {30'd0, e[9:8]});
    check("rd_data", {24'd0, o_rd},   {24'd0, e[7:0]});
  endtask

  task automatic idle(input logic rch);
    drive(1'b0, 1'b0, 1'b0, 8'd0, rch, 1'b0);
  endtask

  task automatic wait_model_tick(input logic rch);
    int guard = 0;
    while (!m_tick && guard < 20) begin
      idle(rch);
      guard++;
    end
  endtask

  initial begin
    int ticks, first, pulses, k;
    m_cnt[0] = 8'd0; m_cnt[1] = 8'd0; m_exp = 2'b00; m_tick = 1'b0; m_n = 0;

    // 1: reset release, free running
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("rst_rd", {24'd0, o_rd}, 32'd0);
    check("rst_act", {30'd0, o_act}, 32'd0);
    ticks = 0; first = 0;
    for (int i = 1; i <= 25; i++) begin
      idle(i[0]);
      if (o_tick) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    check("t1_tick_count", ticks, 3);
    check("t1_first_tick", first, 8);

    // 2: ch0 = 8 counts down and expires once
    drive(1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0);
    check("t2_load", {24'd0, o_rd}, 32'd8);
    pulses = 0;
    for (int i = 0; i < 72; i++) begin
      idle(1'b0);
      if (o_exp[0]) begin
        pulses++;
        check("t2_rd_at_expiry", {24'd0, o_rd}, 32'd0);
      end
    end
    check("t2_pulses", pulses, 1);
    check("t2_act_end", {30'd0, o_act}, 32'd0);

    // 3: write ch1 in a tick cycle while ch0 = 5
    wait_model_tick(1'b0);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
    wait_model_tick(1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0);
    check("t3_ch1", {24'd0, o_rd}, 32'd3);
    check("t3_exp", {30'd0, o_exp}, 32'd0);
    idle(1'b0);
    check("t3_ch0", {24'd0, o_rd}, 32'd4);

    // 4: clear channels silently before expiry
    drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check("t4_clear", {24'd0, o_rd}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      idle(i[0]);
      if (o_exp != 2'b00) pulses++;
    end
    check("t4_no_expiry", pulses, 0);

    // 5: reset mid-count
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("t5_rd", {24'd0, o_rd}, 32'd0);
    check("t5_act", {30'd0, o_act}, 32'd0);
    k = 0;
    do begin
      idle(1'b0);
      k++;
    end while (!o_tick && k < 20);
    check("t5_first_tick", k, 8);

`ifdef CHIP8_TIMER_PAUSE_EN
    // 6: pause freezes count and prescaler phase
    drive(1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      if (o_tick) ticks++;
    end
    check("t6_paused_ticks", ticks, 0);
    check("t6_held", {24'd0, o_rd}, 32'd4);
    for (int i = 0; i < 20; i++) idle(1'b0);
`endif

    // Random writes and reads
    for (int i = 0; i < 200; i++) begin
      logic pz;
      pz = 1'b0;
`ifdef CHIP8_TIMER_PAUSE_EN
      pz = ($urandom_range(0, 7) == 0);
`endif
      drive(1'b0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), pz);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
